// File: rtl/segre_mem_arbiter.sv
// Two-requester (icache/dcache) line arbiter in front of a single memory port.
// Fair tie-break on last-served; one transfer at a time through IDLE -> MEM -> DONE.
module segre_mem_arbiter #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                      clk_i,
    input  logic                      rsn_i,
    input  logic                      ic_rd_i,
    input  logic                      ic_wr_i,
    input  logic [WORD_SIZE-1:0]      ic_addr_i,
    input  logic [LINE_BYTES*8-1:0]   ic_line_i,
    input  logic                      dc_rd_i,
    input  logic                      dc_wr_i,
    input  logic [WORD_SIZE-1:0]      dc_addr_i,
    input  logic [LINE_BYTES*8-1:0]   dc_line_i,
    output logic                      ic_rcvd_o,
    output logic                      dc_rcvd_o,
    output logic [LINE_BYTES*8-1:0]   line_o,
    output logic                      mem_rd_o,
    output logic                      mem_wr_o,
    output logic [WORD_SIZE-1:0]      mem_addr_o,
    output logic [LINE_BYTES*8-1:0]   mem_line_o,
    input  logic [LINE_BYTES*8-1:0]   mem_line_i,
    input  logic                      mem_ack_i,
    output logic                      busy_o
);

    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~(WORD_SIZE'(LINE_BYTES - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Owner / last-served encoding: 0 = icache, 1 = dcache.
    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic                   op_wr_q, op_wr_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]      wline_q, wline_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;
    logic                   ic_rcvd_q, ic_rcvd_d;
    logic                   dc_rcvd_q, dc_rcvd_d;
    logic                   busy_q, busy_d;

    logic                   ic_pend_c;
    logic                   dc_pend_c;
    logic                   grant_dc_c;

    assign ic_pend_c  = ic_rd_i | ic_wr_i;
    assign dc_pend_c  = dc_rd_i | dc_wr_i;
    // On a tie the requester not served last wins.
    assign grant_dc_c = dc_pend_c & (~ic_pend_c | ~last_q);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wline_q   <= '0;
            line_q    <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            ic_rcvd_q <= 1'b0;
            dc_rcvd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            line_q    <= line_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            ic_rcvd_q <= ic_rcvd_d;
            dc_rcvd_q <= dc_rcvd_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and latch control; write wins when rd and wr are both held.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        line_d  = line_q;
        case (state_q)
            S_IDLE: begin
                if (ic_pend_c || dc_pend_c) begin
                    state_d = S_MEM;
                    owner_d = grant_dc_c;
                    op_wr_d = grant_dc_c ? dc_wr_i : ic_wr_i;
                    addr_d  = (grant_dc_c ? dc_addr_i : ic_addr_i) & ALIGN_MASK;
                    wline_d = grant_dc_c ? dc_line_i : ic_line_i;
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    state_d = S_DONE;
                    last_d  = owner_q;
                    if (!op_wr_q) begin
                        line_d = mem_line_i;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        mem_rd_d  = (state_d == S_MEM) && !op_wr_d;
        mem_wr_d  = (state_d == S_MEM) &&  op_wr_d;
        ic_rcvd_d = (state_d == S_DONE) && !owner_d;
        dc_rcvd_d = (state_d == S_DONE) &&  owner_d;
        busy_d    = (state_d != S_IDLE);
    end

    assign ic_rcvd_o  = ic_rcvd_q;
    assign dc_rcvd_o  = dc_rcvd_q;
    assign line_o     = line_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_wr_o   = mem_wr_q;
    assign mem_addr_o = addr_q;
    assign mem_line_o = wline_q;
    assign busy_o     = busy_q;

endmodule
